// File: rtl/dwrr_pkt_sched.sv
// ============================================================================
// Module   : dwrr_pkt_sched
// Purpose  : Deficit-weighted round-robin scheduler for multi-beat packets.
//            Holds a one-hot grant for the whole packet. A downstream stall
//            (blk_i) holds individual beats back.
// Options  : STRICT_PRI_EN - requester 0 becomes strict high priority and is
//            removed from the deficit rotation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwrr_pkt_sched #(
  parameter int NUM_REQS = 4,
  parameter int QWID     = 8,
  parameter int LWID     = 8,
  parameter int DWID     = QWID + 1,
  parameter int CNTWID   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQS-1:0]      reqs_i,
  input  logic [NUM_REQS*LWID-1:0] pkt_lens_i,
  input  logic [NUM_REQS*QWID-1:0] input_quantums_i,
  input  logic                     blk_i,
  output logic [NUM_REQS-1:0]      gnt_o,
  output logic [CNTWID-1:0]        gnt_idx_o,
  output logic                     beat_vld_o,
  output logic                     pkt_last_o,
  output logic                     busy_o
);

  localparam int CW = ((DWID > LWID) ? DWID : LWID) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VISIT = 2'd1,
    XFER  = 2'd2,
    CHECK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNTWID-1:0] ptr_q, ptr_d;
  logic [DWID-1:0]   def_q [NUM_REQS];
  logic [DWID-1:0]   def_d [NUM_REQS];
  logic [LWID-1:0]   len_q, len_d;
  logic [LWID-1:0]   beat_cnt_q, beat_cnt_d;
`ifdef STRICT_PRI_EN
  logic              pri_q, pri_d;
  state_e            ret_q, ret_d;
`endif

  logic [LWID-1:0]   len_eff [NUM_REQS];
  logic [QWID-1:0]   quant   [NUM_REQS];

  // Unpack the per-requester fields; a zero length counts as one beat.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
    assign len_eff[gi] = (pkt_lens_i[gi*LWID +: LWID] == '0) ? LWID'(1)
                                                             : pkt_lens_i[gi*LWID +: LWID];
    assign quant[gi]   = input_quantums_i[gi*QWID +: QWID];
  end

  logic              p_req;
  logic [DWID-1:0]   p_def;
  logic [LWID-1:0]   p_len;
  logic [DWID:0]     sum;
  logic [DWID-1:0]   sat;
  logic              sat_ge_len;
  logic              def_ge_len;
  logic [CNTWID-1:0] xfer_idx;

  assign p_req      = reqs_i[ptr_q];
  assign p_def      = def_q[ptr_q];
  assign p_len      = len_eff[ptr_q];
  assign sum        = {1'b0, p_def} + {{(DWID+1-QWID){1'b0}}, quant[ptr_q]};
  assign sat        = sum[DWID] ? {DWID{1'b1}} : sum[DWID-1:0];
  assign sat_ge_len = CW'(sat) >= CW'(p_len);
  assign def_ge_len = CW'(p_def) >= CW'(p_len);
`ifdef STRICT_PRI_EN
  assign xfer_idx   = pri_q ? '0 : ptr_q;
`else
  assign xfer_idx   = ptr_q;
`endif

  // Round-robin successor; with strict priority, slot 0 is never visited.
  function automatic logic [CNTWID-1:0] ptr_next(input logic [CNTWID-1:0] p);
    logic [CNTWID-1:0] n;
    n = (p == CNTWID'(NUM_REQS-1)) ? '0 : p + CNTWID'(1);
`ifdef STRICT_PRI_EN
    if (n == '0) n = CNTWID'(1);
`endif
    return n;
  endfunction

  // Next-state, deficit update and output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    def_d      = def_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
`ifdef STRICT_PRI_EN
    pri_d      = pri_q;
    ret_d      = ret_q;
`endif
    gnt_o      = '0;
    gnt_idx_o  = '0;
    beat_vld_o = 1'b0;
    pkt_last_o = 1'b0;
    busy_o     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (|reqs_i) state_d = VISIT;
      end

      VISIT: begin
`ifdef STRICT_PRI_EN
        if (reqs_i[0]) begin
          pri_d   = 1'b1;
          ret_d   = VISIT;
          len_d   = len_eff[0];
          state_d = XFER;
        end else if (ptr_q == '0) begin
          ptr_d = ptr_next(ptr_q);
          if (~|reqs_i) state_d = IDLE;
        end else
`endif
        if (!p_req) begin
          def_d[ptr_q] = '0;
          ptr_d        = ptr_next(ptr_q);
          if (~|reqs_i) state_d = IDLE;
        end else begin
          def_d[ptr_q] = sat;
          if (sat_ge_len) begin
            len_d   = p_len;
            state_d = XFER;
          end else begin
            ptr_d = ptr_next(ptr_q);
          end
        end
      end

      XFER: begin
        gnt_o[xfer_idx] = 1'b1;
        gnt_idx_o       = xfer_idx;
        beat_vld_o      = ~blk_i;
        if (!blk_i) begin
          if (beat_cnt_q == len_q - LWID'(1)) begin
            pkt_last_o = 1'b1;
            beat_cnt_d = '0;
`ifdef STRICT_PRI_EN
            if (pri_q) begin
              pri_d   = 1'b0;
              state_d = ret_q;
            end else
`endif
            begin
              def_d[ptr_q] = p_def - DWID'(len_q);
              state_d      = CHECK;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LWID'(1);
          end
        end
      end

      CHECK: begin
`ifdef STRICT_PRI_EN
        if (reqs_i[0]) begin
          pri_d   = 1'b1;
          ret_d   = CHECK;
          len_d   = len_eff[0];
          state_d = XFER;
        end else
`endif
        if (p_req && def_ge_len) begin
          len_d   = p_len;
          state_d = XFER;
        end else begin
          if (!p_req) def_d[ptr_q] = '0;
          ptr_d   = ptr_next(ptr_q);
          state_d = (|reqs_i) ? VISIT : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; an asynchronous reset aborts any packet in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      for (int i = 0; i < NUM_REQS; i++) def_q[i] <= '0;
`ifdef STRICT_PRI_EN
      pri_q      <= 1'b0;
      ret_q      <= IDLE;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      for (int i = 0; i < NUM_REQS; i++) def_q[i] <= def_d[i];
`ifdef STRICT_PRI_EN
      pri_q      <= pri_d;
      ret_q      <= ret_d;
`endif
    end
  end

endmodule

`default_nettype wire
